// File: rtl/timer_irq_ctrl.sv
// Machine-timer controller: 64-bit uptime counter driven by a prescaler,
// 64-bit compare with one-shot/periodic re-arm, W1C pending flag and a
// registered level interrupt. Bus reads have one cycle of latency.
module timer_irq_ctrl #(
  parameter int unsigned CLK_DIV   = 100,
  parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int unsigned PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_PERIOD   = 3'd4;
  localparam logic [2:0] A_CTRL     = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   cmp_q, cmp_d;
  logic [31:0]   period_q, period_d;
  logic          en_q, en_d;
  logic          periodic_q, periodic_d;
  logic          ie_q, ie_d;
  logic          pend_q, pend_d;
  logic [31:0]   dout_q, dout_d;
  logic          irq_q, irq_d;

  logic [2:0]    reg_idx;
  logic          wr, rd;
  logic          wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_period, wr_ctrl;
  logic          tick, hit, reload;
  logic [31:0]   rdata;
  logic          unused_addr;

  assign reg_idx     = addr[4:2];
  assign wr          = sel & we;
  assign rd          = sel & ~we;
  assign wr_mtime_lo = wr && (reg_idx == A_MTIME_LO);
  assign wr_mtime_hi = wr && (reg_idx == A_MTIME_HI);
  assign wr_cmp_lo   = wr && (reg_idx == A_CMP_LO);
  assign wr_cmp_hi   = wr && (reg_idx == A_CMP_HI);
  assign wr_period   = wr && (reg_idx == A_PERIOD);
  assign wr_ctrl     = wr && (reg_idx == A_CTRL);
  assign unused_addr = ^{addr[31:5], addr[1:0]};

  assign tick = (presc_q == PRESC_MAX);
  assign hit  = (mtime_q >= cmp_q);

  // Prescaler and uptime counter; a bus write to either mtime half wins over a tick
  always_comb begin
    presc_d = presc_q + PW'(1);
    mtime_d = mtime_q;
    if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end
    if (wr_mtime_lo) begin
      presc_d = '0;
      mtime_d = {mtime_q[63:32], din};
    end else if (wr_mtime_hi) begin
      presc_d = '0;
      mtime_d = {din, mtime_q[31:0]};
    end
  end

  // Arm/fire FSM plus control, compare and period register updates
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    ie_d       = ie_q;
    pend_d     = pend_q;
    period_d   = period_q;
    reload     = 1'b0;

    if (wr_ctrl) begin
      en_d       = din[0];
      periodic_d = din[1];
      ie_d       = din[2];
      if (din[3]) begin
        pend_d = 1'b0;
      end
    end
    if (wr_period) begin
      period_d = din;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wr_ctrl && din[0]) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (wr_ctrl && !din[0]) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          pend_d = 1'b1;
          if (periodic_q) begin
            reload = 1'b1;
          end else begin
            en_d    = 1'b0;
            state_d = ST_FIRED;
          end
        end
      end
      ST_FIRED: begin
        if (wr_ctrl && din[0]) begin
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmp_d = cmp_q;
    if (wr_cmp_lo) begin
      cmp_d = {cmp_q[63:32], din};
    end else if (wr_cmp_hi) begin
      cmp_d = {din, cmp_q[31:0]};
    end else if (reload) begin
      cmp_d = cmp_q + {32'b0, period_q};
    end
  end

  // Read mux and registered outputs; reads see pre-edge register values
  always_comb begin
    rdata = '0;
    unique case (reg_idx)
      A_MTIME_LO: rdata = mtime_q[31:0];
      A_MTIME_HI: rdata = mtime_q[63:32];
      A_CMP_LO:   rdata = cmp_q[31:0];
      A_CMP_HI:   rdata = cmp_q[63:32];
      A_PERIOD:   rdata = period_q;
      A_CTRL:     rdata = {28'b0, pend_q, ie_q, periodic_q, en_q};
      default:    rdata = '0;
    endcase
    dout_d = rd ? rdata : dout_q;
    irq_d  = pend_q & ie_q;
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      cmp_q      <= RESET_CMP;
      period_q   <= '0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      pend_q     <= 1'b0;
      dout_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      ie_q       <= ie_d;
      pend_q     <= pend_d;
      dout_q     <= dout_d;
      irq_q      <= irq_d;
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: mtime is modelled as an anchor value plus
// elapsed-edges / DIV, interrupt edges are predicted arithmetically.
module tb_timer_irq_ctrl;

  localparam int unsigned DIV = 4;
  localparam int DIVI = int'(DIV);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] din   = '0;
  logic [31:0] dout;
  logic        irq;

  timer_irq_ctrl #(
    .CLK_DIV  (DIV),
    .RESET_CMP(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          anchor_e = 0;
  logic [63:0] anchor_v = '0;
  logic [63:0] cmp_m = '1;
  logic [31:0] period_m = '0;

  // Uptime value held after edge e
  function automatic logic [63:0] mtime_at(input int e);
    return anchor_v + 64'((e - anchor_e) / DIVI);
  endfunction

  // Expected read data for a read issued at edge e
  function automatic logic [31:0] model_reg(input logic [2:0] idx, input int e,
                                            input logic [31:0] ctrl_exp);
    logic [63:0] m;
    m = mtime_at(e - 1);
    case (idx)
      3'd0:    return m[31:0];
      3'd1:    return m[63:32];
      3'd2:    return cmp_m[31:0];
      3'd3:    return cmp_m[63:32];
      3'd4:    return period_m;
      3'd5:    return ctrl_exp;
      default: return 32'h0;
    endcase
  endfunction

  task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
    int e;
    logic [63:0] cur;
    addr = {27'($urandom), idx, 2'($urandom)};
    din  = data;
    sel  = 1'b1;
    we   = 1'b1;
    @(negedge clock);
    sel = 1'b0;
    we  = 1'b0;
    e   = cyc;
    cur = mtime_at(e - 1);
    case (idx)
      3'd0: begin anchor_v = {cur[63:32], data}; anchor_e = e; end
      3'd1: begin anchor_v = {data, cur[31:0]};  anchor_e = e; end
      3'd2: cmp_m[31:0]  = data;
      3'd3: cmp_m[63:32] = data;
      3'd4: period_m     = data;
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [2:0] idx, output logic [31:0] data, output int e);
    addr = {27'($urandom), idx, 2'($urandom)};
    sel  = 1'b1;
    we   = 1'b0;
    @(negedge clock);
    sel  = 1'b0;
    data = dout;
    e    = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    logic [31:0] d, x;
    int e;
    reset = 1'b1;
    idle(3);
    n_cmp++;
    if (irq !== 1'b0 || dout !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: irq=%b dout=%h, required irq=0 dout=0", irq, dout);
    end
    reset    = 1'b0;
    anchor_e = cyc;
    anchor_v = '0;
    cmp_m    = '1;
    period_m = '0;
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), d, e);
      x = model_reg(3'(i), e, 32'h0);
      n_cmp++;
      if (d !== x) begin
        n_bad++;
        $display("FAIL reset_reg%0d: got %h, required %h", i, d, x);
      end
    end
  endtask

  task automatic test_prescaler;
    logic [31:0] d, x;
    int e;
    for (int i = 0; i < 4; i++) begin
      idle((i == 0) ? 40 : int'($urandom_range(1, 40)));
      for (int h = 0; h < 2; h++) begin
        bus_read(3'(h), d, e);
        x = model_reg(3'(h), e, 32'h0);
        n_cmp++;
        if (d !== x) begin
          n_bad++;
          $display("FAIL mtime_count_%0d_%0d: got %h, required %h", i, h, d, x);
        end
      end
    end
    idle(5);
    n_cmp++;
    if (dout !== x) begin
      n_bad++;
      $display("FAIL dout_hold: got %h, required %h", dout, x);
    end
  endtask

  task automatic test_random_regs;
    logic [31:0] d, x;
    logic [2:0]  idx;
    int e;
    bus_write(3'd2, $urandom);
    bus_write(3'd3, $urandom);
    bus_write(3'd4, $urandom);
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0:       idx = 3'd2;
        1:       idx = 3'd3;
        2:       idx = 3'd4;
        3:       idx = 3'd6;
        default: idx = 3'd7;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        bus_write(idx, $urandom);
      end else begin
        bus_read(idx, d, e);
        x = model_reg(idx, e, 32'h0);
        n_cmp++;
        if (d !== x) begin
          n_bad++;
          $display("FAIL rand_reg%0d_op%0d: got %h, required %h", idx, i, d, x);
        end
      end
    end
    for (int i = 2; i < 8; i++) begin
      bus_read(3'(i), d, e);
      x = model_reg(3'(i), e, 32'h0);
      n_cmp++;
      if (d !== x) begin
        n_bad++;
        $display("FAIL rand_final_reg%0d: got %h, required %h", i, d, x);
      end
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    int e, c, exp_e, got_e;
    c = int'($urandom_range(3, 8));
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'h0);
    bus_write(3'd3, 32'h0);
    bus_write(3'd2, 32'(c));
    bus_write(3'd5, 32'h5);
    exp_e = anchor_e + DIVI * c + 2;
    got_e = -1;
    for (int i = 0; i < 200; i++) begin
      if (irq === 1'b1) begin
        got_e = cyc;
        break;
      end
      @(negedge clock);
    end
    n_cmp++;
    if (got_e != exp_e) begin
      n_bad++;
      $display("FAIL oneshot_irq_edge: got %0d, required %0d", got_e, exp_e);
    end
    bus_read(3'd5, d, e);
    n_cmp++;
    if (d !== 32'hC) begin
      n_bad++;
      $display("FAIL oneshot_ctrl: got %h, required %h", d, 32'hC);
    end
    bus_write(3'd5, 32'h8);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL oneshot_irq_lag: got %b, required 1", irq);
    end
    idle(1);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL oneshot_irq_clear: got %b, required 0", irq);
    end
    idle(8);
    bus_read(3'd5, d, e);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL fired_no_refire: got %h, required %h", d, 32'h0);
    end
  endtask

  task automatic test_periodic;
    logic [31:0] d;
    int e, c0, p, ck, exp_e, got_e;
    c0 = int'($urandom_range(8, 12));
    p  = int'($urandom_range(6, 12));
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'h0);
    bus_write(3'd3, 32'h0);
    bus_write(3'd2, 32'(c0));
    bus_write(3'd4, 32'(p));
    bus_write(3'd5, 32'h7);
    for (int k = 0; k < 3; k++) begin
      ck    = c0 + k * p;
      exp_e = anchor_e + DIVI * ck + 2;
      got_e = -1;
      for (int i = 0; i < DIVI * p + 60; i++) begin
        if (irq === 1'b1) begin
          got_e = cyc;
          break;
        end
        @(negedge clock);
      end
      n_cmp++;
      if (got_e != exp_e) begin
        n_bad++;
        $display("FAIL periodic_fire%0d_edge: got %0d, required %0d", k, got_e, exp_e);
      end
      if (k == 0) begin
        bus_read(3'd5, d, e);
        n_cmp++;
        if (d !== 32'hF) begin
          n_bad++;
          $display("FAIL periodic_ctrl: got %h, required %h", d, 32'hF);
        end
      end
      bus_write(3'd5, 32'hF);
      idle(1);
      n_cmp++;
      if (irq !== 1'b0) begin
        n_bad++;
        $display("FAIL periodic_clear%0d: got %b, required 0", k, irq);
      end
    end
    bus_read(3'd2, d, e);
    n_cmp++;
    if (d !== 32'(c0 + 3 * p)) begin
      n_bad++;
      $display("FAIL periodic_cmp_lo: got %h, required %h", d, 32'(c0 + 3 * p));
    end
    bus_read(3'd3, d, e);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL periodic_cmp_hi: got %h, required %h", d, 32'h0);
    end
    bus_write(3'd5, 32'h0);
  endtask

  task automatic test_mtime_wrap;
    logic [31:0] d, x, v;
    int e;
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'h0);
    idle(6);
    for (int h = 1; h >= 0; h--) begin
      bus_read(3'(h), d, e);
      x = model_reg(3'(h), e, 32'h0);
      n_cmp++;
      if (d !== x) begin
        n_bad++;
        $display("FAIL carry_half%0d: got %h, required %h", h, d, x);
      end
    end
    while ((cyc + 1 - anchor_e) % DIVI != 0) @(negedge clock);
    v = $urandom;
    bus_write(3'd0, v);
    bus_read(3'd0, d, e);
    n_cmp++;
    if (d !== v) begin
      n_bad++;
      $display("FAIL write_beats_tick: got %h, required %h", d, v);
    end
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd0, 32'hFFFF_FFFF);
    idle(5);
    for (int h = 1; h >= 0; h--) begin
      bus_read(3'(h), d, e);
      x = model_reg(3'(h), e, 32'h0);
      n_cmp++;
      if (d !== x) begin
        n_bad++;
        $display("FAIL wrap64_half%0d: got %h, required %h", h, d, x);
      end
    end
  endtask

  task automatic test_w1c_race;
    logic [31:0] d;
    int e;
    bus_write(3'd2, 32'h0);
    bus_write(3'd3, 32'h0);
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h3);
    idle(2);
    bus_write(3'd5, 32'hB);
    bus_read(3'd5, d, e);
    n_cmp++;
    if (d !== 32'hB) begin
      n_bad++;
      $display("FAIL w1c_set_wins: got %h, required %h", d, 32'hB);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL ie_masks_irq: got %b, required 0", irq);
    end
    bus_read(3'd2, d, e);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL period0_cmp: got %h, required %h", d, 32'h0);
    end
    bus_write(3'd5, 32'h8);
    idle(3);
    bus_read(3'd5, d, e);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL disable_idle: got %h, required %h", d, 32'h0);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, x;
    int e, got_e;
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'h0);
    bus_write(3'd3, 32'h0);
    bus_write(3'd2, 32'h2);
    bus_write(3'd5, 32'h5);
    got_e = -1;
    for (int i = 0; i < 80; i++) begin
      if (irq === 1'b1) begin
        got_e = cyc;
        break;
      end
      @(negedge clock);
    end
    n_cmp++;
    if (got_e != anchor_e + DIVI * 2 + 2) begin
      n_bad++;
      $display("FAIL mid_irq_edge: got %0d, required %0d", got_e, anchor_e + DIVI * 2 + 2);
    end
    bus_read(3'd0, d, e);
    x = model_reg(3'd0, e, 32'h0);
    n_cmp++;
    if (d !== x) begin
      n_bad++;
      $display("FAIL mid_mtime: got %h, required %h", d, x);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (irq !== 1'b0 || dout !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: irq=%b dout=%h, required irq=0 dout=0", irq, dout);
    end
    idle(2);
    reset    = 1'b0;
    anchor_e = cyc;
    anchor_v = '0;
    cmp_m    = '1;
    period_m = '0;
    for (int i = 0; i < 6; i++) begin
      bus_read(3'(i), d, e);
      x = model_reg(3'(i), e, 32'h0);
      n_cmp++;
      if (d !== x) begin
        n_bad++;
        $display("FAIL post_reset_reg%0d: got %h, required %h", i, d, x);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_irq: got %b, required 0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_random_regs();
    test_oneshot();
    test_periodic();
    test_mtime_wrap();
    test_w1c_race();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
